// File: rtl/wb_rr_arbiter_b3_if.sv
// Wishbone B3 bus bundle shared by the requesters and the downstream expander port.
// Handshake: cyc&stb is the request (valid); ack/err/rty is the single-cycle termination
// (ready). A beat completes on a rising edge where stb and one termination are both high.
interface wishbone_b3;
  logic [31:0] adr;
  logic [31:0] dat_m2s;
  logic [31:0] dat_s2m;
  logic [3:0]  sel;
  logic        we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output adr, dat_m2s, sel, we, cti, bte, cyc, stb,
    input  dat_s2m, ack, err, rty
  );

  modport slave (
    input  adr, dat_m2s, sel, we, cti, bte, cyc, stb,
    output dat_s2m, ack, err, rty
  );
endinterface

// File: rtl/wb_rr_arbiter_b3.sv
// Round-robin Wishbone B3 arbiter: N requesters share one downstream bus, with a
// stall watchdog that aborts a hung transfer by returning err to the owner.
module wb_rr_arbiter_b3 #(
  parameter int MASTERS = 3,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  wishbone_b3.slave          master [MASTERS],
  wishbone_b3.master         slave,
  output logic [MASTERS-1:0] grant,
  output logic               timeout_pulse,
  output logic [1:0]         state_dbg
);

  localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ABORT = 2'd2
  } state_e;

  state_e        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] owner_nxt;
  logic [7:0]    wdog;

  logic          owned;
  logic          aborting;
  logic          stalled;
  logic          any_req;
  logic [PW-1:0] pick;
  logic [PW:0]   scan;

  logic [MASTERS-1:0] m_cyc;
  logic [MASTERS-1:0] m_stb;
  logic [MASTERS-1:0] m_we;
  logic [31:0]        m_adr [MASTERS];
  logic [31:0]        m_dat [MASTERS];
  logic [3:0]         m_sel [MASTERS];
  logic [2:0]         m_cti [MASTERS];
  logic [1:0]         m_bte [MASTERS];

  assign owned     = (state == OWNED);
  assign aborting  = (state == ABORT);
  assign state_dbg = state;

  for (genvar i = 0; i < MASTERS; i++) begin : g_port
    assign m_cyc[i] = master[i].cyc;
    assign m_stb[i] = master[i].stb;
    assign m_we[i]  = master[i].we;
    assign m_adr[i] = master[i].adr;
    assign m_dat[i] = master[i].dat_m2s;
    assign m_sel[i] = master[i].sel;
    assign m_cti[i] = master[i].cti;
    assign m_bte[i] = master[i].bte;

    // Responses reach only the owner; the abort cycle forces err and swallows a late ack.
    assign master[i].ack     = grant[i] & owned & slave.ack;
    assign master[i].rty     = grant[i] & owned & slave.rty;
    assign master[i].err     = grant[i] & ((owned & slave.err) | aborting);
    assign master[i].dat_s2m = (grant[i] & owned) ? slave.dat_s2m : '0;
  end

  assign slave.cyc     = owned & m_cyc[owner];
  assign slave.stb     = owned & m_stb[owner];
  assign slave.we      = owned & m_we[owner];
  assign slave.adr     = owned ? m_adr[owner] : '0;
  assign slave.dat_m2s = owned ? m_dat[owner] : '0;
  assign slave.sel     = owned ? m_sel[owner] : '0;
  assign slave.cti     = owned ? m_cti[owner] : '0;
  assign slave.bte     = owned ? m_bte[owner] : '0;

  assign stalled   = slave.stb & ~slave.ack & ~slave.err & ~slave.rty;
  assign owner_nxt = (owner == PW'(MASTERS - 1)) ? '0 : owner + PW'(1);

  // Scan from ptr upward; iterating downward lets the closest requester overwrite pick last.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    scan    = '0;
    for (int k = MASTERS - 1; k >= 0; k--) begin
      scan = {1'b0, ptr} + (PW+1)'(k);
      if (scan >= (PW+1)'(MASTERS)) scan = scan - (PW+1)'(MASTERS);
      if (m_cyc[scan[PW-1:0]]) begin
        any_req = 1'b1;
        pick    = scan[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      owner         <= '0;
      ptr           <= '0;
      wdog          <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (any_req) begin
            state <= OWNED;
            owner <= pick;
            grant <= MASTERS'(1) << pick;
          end
        end
        OWNED: begin
          if (!m_cyc[owner]) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= owner_nxt;
            wdog  <= '0;
          end else if (stalled) begin
            // The edge on which the count reaches TIMEOUT is the edge that enters ABORT.
            wdog <= wdog + 8'd1;
            if (wdog == 8'(TIMEOUT - 1)) begin
              state         <= ABORT;
              timeout_pulse <= 1'b1;
            end
          end else begin
            wdog <= '0;
          end
        end
        ABORT: begin
          state <= IDLE;
          grant <= '0;
          ptr   <= owner_nxt;
          wdog  <= '0;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter_b3.sv
// Directed bench for wb_rr_arbiter_b3 (3 masters, TIMEOUT=4) with a short random one-hot sweep.
module tb_wb_rr_arbiter_b3;

  logic clk;
  logic rst_n;

  logic [2:0]  m_cyc;
  logic [2:0]  m_stb;
  logic [31:0] m_adr [3];
  logic [2:0]  m_cti [3];
  logic [2:0]  m_ack;
  logic [2:0]  m_err;
  logic [2:0]  m_rty;
  logic [31:0] m_rdat [3];

  logic        s_ack;
  logic        s_err;
  logic        s_rty;
  logic [31:0] s_dat;

  logic [2:0]  grant;
  logic        timeout_pulse;
  logic [1:0]  state_dbg;

  logic [2:0]  exp_q [$];
  int tests_run;
  int tests_failed;

  wishbone_b3 m_bus [3] ();
  wishbone_b3 s_bus ();

  for (genvar g = 0; g < 3; g++) begin : g_tb_port
    assign m_bus[g].cyc     = m_cyc[g];
    assign m_bus[g].stb     = m_stb[g];
    assign m_bus[g].adr     = m_adr[g];
    assign m_bus[g].dat_m2s = 32'h0000_00D0 + g;
    assign m_bus[g].sel     = 4'hF;
    assign m_bus[g].we      = 1'b0;
    assign m_bus[g].cti     = m_cti[g];
    assign m_bus[g].bte     = 2'b00;
    assign m_ack[g]         = m_bus[g].ack;
    assign m_err[g]         = m_bus[g].err;
    assign m_rty[g]         = m_bus[g].rty;
    assign m_rdat[g]        = m_bus[g].dat_s2m;
  end

  assign s_bus.ack     = s_ack;
  assign s_bus.err     = s_err;
  assign s_bus.rty     = s_rty;
  assign s_bus.dat_s2m = s_dat;

  wb_rr_arbiter_b3 #(.MASTERS(3), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .master        (m_bus),
    .slave         (s_bus),
    .grant         (grant),
    .timeout_pulse (timeout_pulse),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests_run++; if (grant !== 3'b000) begin tests_failed++; $display("FAIL reset_grant: got %b exp 000", grant); end
    tests_run++; if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin tests_failed++; $display("FAIL reset_slave_cyc: got cyc=%b stb=%b exp 0", s_bus.cyc, s_bus.stb); end
    tests_run++; if (timeout_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout: got %b exp 0", timeout_pulse); end
    tests_run++; if ((m_ack | m_err | m_rty) !== 3'b000) begin tests_failed++; $display("FAIL reset_resp: got %b exp 000", m_ack | m_err | m_rty); end
    tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d exp 0", state_dbg); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++; if (grant !== 3'b000) begin tests_failed++; $display("FAIL post_reset_idle: got %b exp 000", grant); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    tick();
    m_cyc = 3'b111; m_stb = 3'b111;
    #1;
    tests_run++; if (grant !== 3'b000) begin tests_failed++; $display("FAIL rr_arb_cycle: got %b exp 000", grant); end
    for (int j = 0; j < 3; j++) begin
      exp_g = exp_q.pop_front();
      tick();
      s_ack = 1'b1; s_dat = 32'hA000_0000 + j;
      #1;
      tests_run++; if (grant !== exp_g) begin tests_failed++; $display("FAIL rr_grant: got %b exp %b", grant, exp_g); end
      tests_run++; if (s_bus.adr !== m_adr[j]) begin tests_failed++; $display("FAIL rr_adr: got %h exp %h", s_bus.adr, m_adr[j]); end
      tests_run++; if (m_ack !== exp_g) begin tests_failed++; $display("FAIL rr_ack_route: got %b exp %b", m_ack, exp_g); end
      tests_run++; if (m_rdat[j] !== 32'hA000_0000 + j) begin tests_failed++; $display("FAIL rr_rdata: got %h exp %h", m_rdat[j], 32'hA000_0000 + j); end
      tick();
      s_ack = 1'b0; m_cyc[j] = 1'b0; m_stb[j] = 1'b0;
      #1;
      tests_run++; if (s_bus.cyc !== 1'b0) begin tests_failed++; $display("FAIL rr_release_cyc: got %b exp 0", s_bus.cyc); end
      tick();
      tests_run++; if (grant !== 3'b000) begin tests_failed++; $display("FAIL rr_idle_gap: got %b exp 000", grant); end
    end
  endtask

  task automatic test_burst();
    logic [2:0] exp_cti;
    tick();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_cti[1] = 3'b010;
    #1;
    for (int b = 0; b < 8; b++) begin
      tick();
      if (b == 0) begin m_cyc[0] = 1'b1; m_stb[0] = 1'b1; end
      exp_cti = (b == 7) ? 3'b111 : 3'b010;
      m_cti[1] = exp_cti;
      s_ack = 1'b1;
      #1;
      tests_run++; if (grant !== 3'b010) begin tests_failed++; $display("FAIL burst_grant beat %0d: got %b exp 010", b, grant); end
      tests_run++; if (m_ack !== 3'b010) begin tests_failed++; $display("FAIL burst_ack beat %0d: got %b exp 010", b, m_ack); end
      tests_run++; if (s_bus.cti !== exp_cti) begin tests_failed++; $display("FAIL burst_cti beat %0d: got %b exp %b", b, s_bus.cti, exp_cti); end
    end
    tick();
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cti[1] = 3'b000;
    #1;
    tests_run++; if (grant !== 3'b010) begin tests_failed++; $display("FAIL burst_hold_release: got %b exp 010", grant); end
    tick();
    tests_run++; if (grant !== 3'b000) begin tests_failed++; $display("FAIL burst_idle_gap: got %b exp 000", grant); end
    tick();
    s_ack = 1'b1;
    #1;
    tests_run++; if (grant !== 3'b001) begin tests_failed++; $display("FAIL burst_next_owner: got %b exp 001", grant); end
    tests_run++; if (m_ack !== 3'b001) begin tests_failed++; $display("FAIL burst_next_ack: got %b exp 001", m_ack); end
    tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    tick();
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    #1;
    for (int s = 0; s < 4; s++) begin
      tick();
      tests_run++; if (grant !== 3'b100 || s_bus.cyc !== 1'b1) begin tests_failed++; $display("FAIL to_stall %0d: got grant=%b cyc=%b exp 100/1", s, grant, s_bus.cyc); end
      tests_run++; if (timeout_pulse !== 1'b0 || m_err !== 3'b000) begin tests_failed++; $display("FAIL to_early %0d: got pulse=%b err=%b exp 0/000", s, timeout_pulse, m_err); end
    end
    tick();
    tests_run++; if (timeout_pulse !== 1'b1) begin tests_failed++; $display("FAIL to_pulse: got %b exp 1", timeout_pulse); end
    tests_run++; if (m_err !== 3'b100 || m_ack !== 3'b000) begin tests_failed++; $display("FAIL to_err: got err=%b ack=%b exp 100/000", m_err, m_ack); end
    tests_run++; if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin tests_failed++; $display("FAIL to_slave_cyc: got %b exp 0", s_bus.cyc); end
    tests_run++; if (grant !== 3'b100 || state_dbg !== 2'd2) begin tests_failed++; $display("FAIL to_abort_state: got grant=%b st=%0d exp 100/2", grant, state_dbg); end
    tick();
    m_cyc = 3'b011; m_stb = 3'b011;
    #1;
    tests_run++; if (grant !== 3'b000 || timeout_pulse !== 1'b0 || m_err !== 3'b000) begin tests_failed++; $display("FAIL to_after: got grant=%b pulse=%b err=%b exp 000/0/000", grant, timeout_pulse, m_err); end
    tick();
    s_ack = 1'b1;
    #1;
    tests_run++; if (grant !== 3'b001) begin tests_failed++; $display("FAIL to_ptr_wrap: got %b exp 001", grant); end
    tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick();
    tick();
    s_ack = 1'b1;
    #1;
    tests_run++; if (grant !== 3'b010) begin tests_failed++; $display("FAIL to_second: got %b exp 010", grant); end
    tick();
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
  endtask

  task automatic test_late_ack();
    tick();
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    for (int s = 0; s < 4; s++) tick();
    tick();
    s_ack = 1'b1;
    #1;
    tests_run++; if (m_ack !== 3'b000) begin tests_failed++; $display("FAIL late_ack_dropped: got %b exp 000", m_ack); end
    tests_run++; if (m_err !== 3'b100 || timeout_pulse !== 1'b1) begin tests_failed++; $display("FAIL late_ack_err: got err=%b pulse=%b exp 100/1", m_err, timeout_pulse); end
    tick();
    s_ack = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    s_ack = 1'b1;
    #1;
    tests_run++; if (grant !== 3'b001 || m_ack !== 3'b001 || m_err !== 3'b000) begin tests_failed++; $display("FAIL late_ack_next: got grant=%b ack=%b err=%b exp 001/001/000", grant, m_ack, m_err); end
    tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    tests_run++; if (grant !== 3'b001 || s_bus.stb !== 1'b1) begin tests_failed++; $display("FAIL rmid_owned: got grant=%b stb=%b exp 001/1", grant, s_bus.stb); end
    #1;
    rst_n = 1'b0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    #1;
    tests_run++; if (grant !== 3'b000 || s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin tests_failed++; $display("FAIL rmid_async: got grant=%b cyc=%b exp 000/0", grant, s_bus.cyc); end
    tests_run++; if (m_err !== 3'b000 || state_dbg !== 2'd0) begin tests_failed++; $display("FAIL rmid_no_err: got err=%b st=%0d exp 000/0", m_err, state_dbg); end
    tick();
    tests_run++; if (grant !== 3'b000) begin tests_failed++; $display("FAIL rmid_held: got %b exp 000", grant); end
    rst_n = 1'b1;
    tick();
    s_ack = 1'b1;
    #1;
    tests_run++; if (grant !== 3'b001 || m_ack !== 3'b001) begin tests_failed++; $display("FAIL rmid_first: got grant=%b ack=%b exp 001/001", grant, m_ack); end
    tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick();
    tick();
    s_ack = 1'b1;
    #1;
    tests_run++; if (grant !== 3'b010) begin tests_failed++; $display("FAIL rmid_second: got %b exp 010", grant); end
    tick();
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
  endtask

  task automatic test_stb_no_cyc();
    tick();
    m_stb[1] = 1'b1;
    tick();
    tests_run++; if (grant !== 3'b000 || s_bus.stb !== 1'b0) begin tests_failed++; $display("FAIL stb_only: got grant=%b stb=%b exp 000/0", grant, s_bus.stb); end
    tick();
    tests_run++; if (grant !== 3'b000) begin tests_failed++; $display("FAIL stb_only_hold: got %b exp 000", grant); end
    m_stb[1] = 1'b0;
  endtask

  task automatic test_starvation();
    for (int r = 0; r < 3; r++) begin
      tick();
      m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
      tick();
      s_ack = 1'b1;
      #1;
      tests_run++; if (grant !== 3'b100 || m_ack !== 3'b100) begin tests_failed++; $display("FAIL starve round %0d: got grant=%b ack=%b exp 100/100", r, grant, m_ack); end
      tick();
      s_ack = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        m_cyc[i] = 1'($urandom_range(0, 1));
        m_stb[i] = m_cyc[i];
      end
      s_ack = 1'($urandom_range(0, 1));
      s_err = ($urandom_range(0, 7) == 0);
      s_rty = ($urandom_range(0, 7) == 0);
      #1;
      tests_run++; if ($countones(grant) > 1) begin tests_failed++; $display("FAIL rnd_onehot: got %b exp at most one bit", grant); end
      tests_run++; if (((m_ack | m_err | m_rty) & ~grant) !== 3'b000) begin tests_failed++; $display("FAIL rnd_non_owner: got %b exp 000", (m_ack | m_err | m_rty) & ~grant); end
      tests_run++; if (grant == 3'b000 && s_bus.cyc !== 1'b0) begin tests_failed++; $display("FAIL rnd_idle_cyc: got %b exp 0", s_bus.cyc); end
    end
    m_cyc = 3'b000; m_stb = 3'b000;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    m_cyc = 3'b000;
    m_stb = 3'b000;
    for (int i = 0; i < 3; i++) begin
      m_adr[i] = 32'h1000_0000 * (i + 1) + 32'h40;
      m_cti[i] = 3'b000;
    end
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    s_dat = 32'h0;

    test_reset();
    test_round_robin();
    test_burst();
    test_timeout();
    test_late_ack();
    test_reset_mid();
    test_stb_no_cyc();
    test_starvation();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter_b3.md
WB_RR_ARBITER_B3 -- requirements
Module: wb_rr_arbiter_b3

Interface
REQ-001 SHALL have parameter MASTERS, default 3, number of Wishbone B3 requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, slave-stall cycles before forced error (1..255).
REQ-003 SHALL have port clk  input  1  bus clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port master  wishbone_b3.slave array  [MASTERS]  requester-side buses; index 0 = CPU instruction port.
REQ-006 SHALL have port slave  wishbone_b3.master  1  shared downstream bus (expander side).
REQ-007 SHALL have port grant  output  MASTERS  one-hot current owner, all-zero when idle.
REQ-008 SHALL have port timeout_pulse  output  1  one-cycle strobe on watchdog abort.

Function
REQ-009 SHALL implement FSM states IDLE, OWNED, ABORT; reset state IDLE.
REQ-010 IDLE: if any master[i].cyc=1, SHALL select the first requester scanning from pointer ptr upward modulo MASTERS, register grant, and enter OWNED next edge (1-cycle arbitration latency).
REQ-011 IDLE with no cyc SHALL remain IDLE; slave.cyc=slave.stb=0.
REQ-012 OWNED: slave adr, dat_m2s, sel, we, cti, bte, cyc, stb SHALL be combinationally driven from the granted master.
REQ-013 OWNED: slave ack/err/rty and dat_s2m SHALL route only to the granted master; non-granted masters see ack=err=rty=0.
REQ-014 Ownership SHALL persist while granted master's cyc=1 regardless of other requests (burst/locked cycles not interrupted).
REQ-015 Granted cyc falling to 0 SHALL return FSM to IDLE next edge and set ptr=(owner+1) mod MASTERS.
REQ-016 Simultaneous release and new requests: re-arbitration SHALL occur in the following IDLE cycle (exactly one idle bus cycle between owners).
REQ-017 Watchdog counter (8 bits) SHALL increment each OWNED cycle with slave.stb=1 and ack=err=rty=0; SHALL clear on any ack/err/rty, on stb=0, and on leaving OWNED.
REQ-018 Counter reaching TIMEOUT SHALL transition to ABORT next edge.
REQ-019 ABORT (exactly one cycle): slave.cyc=stb=0; granted master err=1, ack=rty=0; timeout_pulse=1; grant held; then IDLE with ptr=(owner+1) mod MASTERS.
REQ-020 A late slave ack arriving during ABORT SHALL be discarded (not forwarded).
REQ-021 grant SHALL be registered, one-hot or zero at all times; never two bits set.
REQ-022 Master with stb=1 but cyc=0 SHALL be ignored for arbitration.
REQ-023 ptr SHALL wrap MASTERS-1 -> 0; ptr width ceil(log2(MASTERS)).

Reset
REQ-024 rst_n=0 SHALL asynchronously force state IDLE, grant=0, ptr=0, counter=0, timeout_pulse=0, slave.cyc=slave.stb=0, all master ack/err/rty=0.
REQ-025 Reset asserted mid-transfer SHALL abort without err to the master; first post-reset arbitration starts at ptr=0.
REQ-026 Deassertion SHALL take effect on the first clk edge after rst_n rises; no outputs glitch high during reset.

Verification
REQ-027 Masters 0,1,2 raise cyc simultaneously after reset, each single transfer acked next cycle -> grants 001, 010, 100 in order, one IDLE cycle between each.
REQ-028 Master 1 holds cyc for 8-beat burst (cti=010) while master 0 requests -> grant stays 010 for all 8 acks; master 0 granted only after master 1 drops cyc.
REQ-029 TIMEOUT=4, slave never acks master 2 -> after 4 stalled cycles ABORT: master[2].err=1 one cycle, timeout_pulse=1, slave.cyc=0, then IDLE with ptr=0.
REQ-030 Slave acks in the ABORT cycle -> master sees err only, no ack; next request proceeds normally.
REQ-031 rst_n pulled low while master 0 owns with stb=1 -> grant=0, slave.cyc=0 immediately (same cycle, async); after release master 1 and 0 requesting -> master 0 granted first.
REQ-032 Only master 2 requesting repeatedly -> served each time (ptr wraps 0), no starvation; random stimulus checks grant one-hot and no response to non-owner.
